// File: rtl/c7bbiu_axi_rd_engine.sv
// rtl/c7bbiu_axi_rd_engine.sv - AXI read-channel engine, one outstanding burst per source
//
// Purpose:
//   Sits between the read arbiter and the external AXI AR/R channels. Requests are
//   captured into a stable AR holding register. Each source may have one burst in
//   flight. Returned beats are counted against the issued len and are routed back
//   to their source through registered outputs. Completion and error status are
//   reported per source.
//
// Ports:
//   clk, resetn             clock, synchronous active-low reset
//   req_*                   request handshake from the arbiter (val/ready, src, addr, len, size, burst)
//   ext_biu_ar_ready        AR channel ready from the fabric
//   biu_ext_ar_*            registered AR channel (valid, id=source, addr, len, size, burst)
//   biu_ext_r_ready         R channel ready, always 1
//   ext_biu_r_*             R channel from the fabric (valid, id, data, last, resp)
//   rd_data, rd_data_val    registered beat data and its one-hot per-source valid
//   rd_data_last            registered beat is the one that ends the burst
//   rd_done, rd_err         per-source completion pulse and its error qualifier
//   rd_unexp_id             pulse when a beat arrived for an idle or unknown id
//   rd_outst_cnt            number of sources with a burst in flight

module c7bbiu_axi_rd_engine #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int ID_W    = 4,
   parameter int NUM_SRC = 2,
   parameter int SRC_W   = 1
) (
   input  logic                clk,
   input  logic                resetn,
   input  logic                req_val,
   output logic                req_ready,
   input  logic [SRC_W-1:0]    req_src,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [7:0]          req_len,
   input  logic [2:0]          req_size,
   input  logic [1:0]          req_burst,
   input  logic                ext_biu_ar_ready,
   output logic                biu_ext_ar_valid,
   output logic [ID_W-1:0]     biu_ext_ar_id,
   output logic [ADDR_W-1:0]   biu_ext_ar_addr,
   output logic [7:0]          biu_ext_ar_len,
   output logic [2:0]          biu_ext_ar_size,
   output logic [1:0]          biu_ext_ar_burst,
   output logic                biu_ext_r_ready,
   input  logic                ext_biu_r_valid,
   input  logic [ID_W-1:0]     ext_biu_r_id,
   input  logic [DATA_W-1:0]   ext_biu_r_data,
   input  logic                ext_biu_r_last,
   input  logic [1:0]          ext_biu_r_resp,
   output logic [DATA_W-1:0]   rd_data,
   output logic [NUM_SRC-1:0]  rd_data_val,
   output logic                rd_data_last,
   output logic [NUM_SRC-1:0]  rd_done,
   output logic [NUM_SRC-1:0]  rd_err,
   output logic                rd_unexp_id,
   output logic [SRC_W:0]      rd_outst_cnt
);

   // AR holding register
   logic                r_ar_valid;
   logic [SRC_W-1:0]    r_ar_src;
   logic [ADDR_W-1:0]   r_ar_addr;
   logic [7:0]          r_ar_len;
   logic [2:0]          r_ar_size;
   logic [1:0]          r_ar_burst;

   // Per-source burst tracking
   logic [NUM_SRC-1:0]  r_src_busy;
   logic [7:0]          r_src_len  [NUM_SRC];
   logic [7:0]          r_beat_cnt [NUM_SRC];
   logic [NUM_SRC-1:0]  r_err_acc;

   // Registered return path
   logic [DATA_W-1:0]   r_rd_data;
   logic [NUM_SRC-1:0]  r_rd_data_val;
   logic                r_rd_data_last;
   logic [NUM_SRC-1:0]  r_rd_done;
   logic [NUM_SRC-1:0]  r_rd_err;
   logic                r_rd_unexp_id;
   logic [SRC_W:0]      r_outst_cnt;

   logic                w_req_busy;
   logic                w_req_src_ok;
   logic                w_accept;
   logic [NUM_SRC-1:0]  w_hit;
   logic [NUM_SRC-1:0]  w_cnt_eq;
   logic [NUM_SRC-1:0]  w_final;
   logic [NUM_SRC-1:0]  w_err_now;
   logic                w_unexp;
   logic                w_resp_err;
   logic                w_any_final;
   logic [SRC_W:0]      w_outst_nxt;

   // Busy lookup for the requesting source; an index beyond NUM_SRC is never accepted
   always_comb begin
      w_req_busy   = 1'b0;
      w_req_src_ok = 1'b0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (req_src == SRC_W'(i)) begin
            w_req_busy   = r_src_busy[i];
            w_req_src_ok = 1'b1;
         end
      end
   end

   assign req_ready = (~r_ar_valid | ext_biu_ar_ready) & ~w_req_busy & w_req_src_ok & resetn;
   assign w_accept  = req_val & req_ready;

   assign w_resp_err = (ext_biu_r_resp != 2'b00);

   // A burst ends on the counted final beat or an early r_last, whichever comes first
   always_comb begin
      w_hit     = '0;
      w_cnt_eq  = '0;
      w_final   = '0;
      w_err_now = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         w_hit[i]     = ext_biu_r_valid & (ext_biu_r_id == ID_W'(i)) & r_src_busy[i];
         w_cnt_eq[i]  = (r_beat_cnt[i] == r_src_len[i]);
         w_final[i]   = w_hit[i] & (w_cnt_eq[i] | ext_biu_r_last);
         w_err_now[i] = r_err_acc[i] | w_resp_err | (ext_biu_r_last != w_cnt_eq[i]);
      end
   end

   assign w_unexp     = ext_biu_r_valid & ~(|w_hit);
   assign w_any_final = |w_final;

   // Accept and completion in the same cycle cancel out
   always_comb begin
      w_outst_nxt = r_outst_cnt;
      if (w_accept && !w_any_final) begin
         if (r_outst_cnt < (SRC_W+1)'(NUM_SRC)) begin
            w_outst_nxt = r_outst_cnt + 1'b1;
         end
      end else if (!w_accept && w_any_final) begin
         if (r_outst_cnt != '0) begin
            w_outst_nxt = r_outst_cnt - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_ar_valid     <= 1'b0;
         r_ar_src       <= '0;
         r_ar_addr      <= '0;
         r_ar_len       <= '0;
         r_ar_size      <= '0;
         r_ar_burst     <= '0;
         r_src_busy     <= '0;
         r_err_acc      <= '0;
         for (int i = 0; i < NUM_SRC; i++) begin
            r_src_len[i]  <= '0;
            r_beat_cnt[i] <= '0;
         end
         r_rd_data      <= '0;
         r_rd_data_val  <= '0;
         r_rd_data_last <= 1'b0;
         r_rd_done      <= '0;
         r_rd_err       <= '0;
         r_rd_unexp_id  <= 1'b0;
         r_outst_cnt    <= '0;
      end else begin
         // A new accept keeps valid high so back-to-back requests issue without a bubble
         if (w_accept) begin
            r_ar_valid <= 1'b1;
            r_ar_src   <= req_src;
            r_ar_addr  <= req_addr;
            r_ar_len   <= req_len;
            r_ar_size  <= req_size;
            r_ar_burst <= req_burst;
         end else if (ext_biu_ar_ready) begin
            r_ar_valid <= 1'b0;
         end

         // Accept and beat for the same source cannot coincide: accept requires ~busy
         for (int i = 0; i < NUM_SRC; i++) begin
            if (w_accept && (req_src == SRC_W'(i))) begin
               r_src_busy[i] <= 1'b1;
               r_src_len[i]  <= req_len;
               r_beat_cnt[i] <= '0;
               r_err_acc[i]  <= 1'b0;
            end else if (w_hit[i]) begin
               r_beat_cnt[i] <= r_beat_cnt[i] + 8'd1;
               r_err_acc[i]  <= r_err_acc[i] | w_resp_err;
               if (w_final[i]) begin
                  r_src_busy[i] <= 1'b0;
               end
            end
         end

         if (|w_hit) begin
            r_rd_data <= ext_biu_r_data;
         end
         r_rd_data_val  <= w_hit;
         r_rd_data_last <= w_any_final;
         r_rd_done      <= w_final;
         r_rd_err       <= w_final & w_err_now;
         r_rd_unexp_id  <= w_unexp;
         r_outst_cnt    <= w_outst_nxt;
      end
   end

   assign biu_ext_ar_valid = r_ar_valid;
   assign biu_ext_ar_id    = ID_W'(r_ar_src);
   assign biu_ext_ar_addr  = r_ar_addr;
   assign biu_ext_ar_len   = r_ar_len;
   assign biu_ext_ar_size  = r_ar_size;
   assign biu_ext_ar_burst = r_ar_burst;
   assign biu_ext_r_ready  = 1'b1;

   assign rd_data      = r_rd_data;
   assign rd_data_val  = r_rd_data_val;
   assign rd_data_last = r_rd_data_last;
   assign rd_done      = r_rd_done;
   assign rd_err       = r_rd_err;
   assign rd_unexp_id  = r_rd_unexp_id;
   assign rd_outst_cnt = r_outst_cnt;

endmodule
